// File: rtl/syn_fifo_ext_if.sv
// Handshake/status bundle for syn_fifo_ext.
// master: producer/consumer side. slave: the FIFO itself.
interface syn_fifo_ext_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 5
);
  logic                 wr_en;
  logic [WIDTH-1:0]     wdata;
  logic                 rd_en;
  logic [WIDTH-1:0]     rdata;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo_ext.sv
// syn_fifo_ext: single-clock FIFO for any DEPTH >= 2, with fill count,
// almost-full/almost-empty thresholds, push+pop while full and
// overflow/underflow pulses.
// Optional feature macro: SYN_FIFO_FWFT_EN selects first-word-fall-through
// reads; when undefined, reads are registered with one cycle of latency.
// The interface instance must use the same WIDTH and CNT_WIDTH = $clog2(DEPTH+1).
module syn_fifo_ext #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           res,
  syn_fifo_ext_if.slave  bus
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 full_q;
  logic                 empty_q;
  logic                 af_q;
  logic                 ae_q;
  logic                 ovf_q;
  logic                 udf_q;
  logic                 rd_ok;
  logic                 wr_ok;

  // Accept/reject decision; a pop in the same cycle frees a slot for a push when full.
  always_comb begin
    rd_ok = bus.rd_en & ~empty_q;
    wr_ok = bus.wr_en & (~full_q | rd_ok);
  end

  // Next occupancy, used to register all flags with zero extra latency.
  always_comb begin
    count_next = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + CNT_WIDTH'(1);
      2'b01:   count_next = count_q - CNT_WIDTH'(1);
      default: count_next = count_q;
    endcase
  end

  // Storage write; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= bus.wdata;
    end
  end

  // Pointers (explicit wrap at DEPTH-1), count, flags and reject pulses.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
      end
      if (rd_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
      end
      count_q <= count_next;
      full_q  <= (count_next == CNT_WIDTH'(DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CNT_WIDTH'(AF_THRESH));
      ae_q    <= (count_next <= CNT_WIDTH'(AE_THRESH));
      ovf_q   <= bus.wr_en & ~wr_ok;
      udf_q   <= bus.rd_en & ~rd_ok;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  // Head word is visible combinationally; value is don't-care while empty.
  always_comb begin
    bus.rdata = mem[rd_ptr_q];
  end
`else
  logic [WIDTH-1:0] rdata_q;

  // Registered read: rdata updates only on an accepted pop, otherwise holds.
  always_ff @(posedge clk) begin
    if (res) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem[rd_ptr_q];
    end
  end

  // Drive registered read data onto the bus.
  always_comb begin
    bus.rdata = rdata_q;
  end
`endif

  // Status outputs straight from registers.
  always_comb begin
    bus.full         = full_q;
    bus.empty        = empty_q;
    bus.almost_full  = af_q;
    bus.almost_empty = ae_q;
    bus.count        = count_q;
    bus.overflow     = ovf_q;
    bus.underflow    = udf_q;
  end

endmodule

// File: tb/tb_syn_fifo_ext.sv
// Directed self-checking bench for syn_fifo_ext: a DEPTH=16 instance for
// fill/overflow/underflow/push+pop-when-full, and a DEPTH=10 instance for
// non-power-of-two wrap-around. Read-data checks follow SYN_FIFO_FWFT_EN.
module tb_syn_fifo_ext;

  logic clk = 1'b0;
  logic res_a;
  logic res_b;
  int   checks = 0;
  int   errors = 0;
  int   nb;

  always #5 clk = ~clk;

  syn_fifo_ext_if #(.WIDTH(8), .CNT_WIDTH(5)) a ();
  syn_fifo_ext_if #(.WIDTH(8), .CNT_WIDTH(4)) b ();

  syn_fifo_ext #(.WIDTH(8), .DEPTH(16)) u16 (.clk(clk), .res(res_a), .bus(a));
  syn_fifo_ext #(.WIDTH(8), .DEPTH(10)) u10 (.clk(clk), .res(res_b), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_a(input logic [7:0] exp);
`ifdef SYN_FIFO_FWFT_EN
    chk("pop_a_data", 32'(a.rdata), 32'(exp));
    a.rd_en = 1'b1; cycle(); a.rd_en = 1'b0;
`else
    a.rd_en = 1'b1; cycle(); a.rd_en = 1'b0;
    chk("pop_a_data", 32'(a.rdata), 32'(exp));
`endif
  endtask

  task automatic pop_b(input logic [7:0] exp);
`ifdef SYN_FIFO_FWFT_EN
    chk("pop_b_data", 32'(b.rdata), 32'(exp));
    b.rd_en = 1'b1; cycle(); b.rd_en = 1'b0;
`else
    b.rd_en = 1'b1; cycle(); b.rd_en = 1'b0;
    chk("pop_b_data", 32'(b.rdata), 32'(exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res_a = 1'b1; res_b = 1'b1;
    a.wr_en = 1'b0; a.rd_en = 1'b0; a.wdata = '0;
    b.wr_en = 1'b0; b.rd_en = 1'b0; b.wdata = '0;
    cycle(); cycle();
    res_a = 1'b0; res_b = 1'b0;

    // Reset state
    chk("rst_count", 32'(a.count), 0);
    chk("rst_empty", 32'(a.empty), 1);
    chk("rst_full", 32'(a.full), 0);
    chk("rst_af", 32'(a.almost_full), 0);
    chk("rst_ae", 32'(a.almost_empty), 1);
    chk("rst_ovf", 32'(a.overflow), 0);
    chk("rst_udf", 32'(a.underflow), 0);
`ifndef SYN_FIFO_FWFT_EN
    chk("rst_rdata", 32'(a.rdata), 0);
`endif
    chk("rst_b_count", 32'(b.count), 0);
    chk("rst_b_empty", 32'(b.empty), 1);

    // Read on empty is rejected with a one-cycle pulse
    a.rd_en = 1'b1; cycle(); a.rd_en = 1'b0;
    chk("udf_empty_pulse", 32'(a.underflow), 1);
    chk("udf_empty_count", 32'(a.count), 0);
    cycle();
    chk("udf_empty_clear", 32'(a.underflow), 0);

    // Empty + write + read: write accepted, read rejected
    a.wr_en = 1'b1; a.rd_en = 1'b1; a.wdata = 8'h11; cycle();
    a.wr_en = 1'b0; a.rd_en = 1'b0;
    chk("wr_rd_empty_count", 32'(a.count), 1);
    chk("wr_rd_empty_udf", 32'(a.underflow), 1);
    chk("wr_rd_empty_empty", 32'(a.empty), 0);
    chk("wr_rd_empty_ovf", 32'(a.overflow), 0);
`ifndef SYN_FIFO_FWFT_EN
    chk("wr_rd_empty_rdata_hold", 32'(a.rdata), 0);
`endif
    pop_a(8'h11);
    chk("single_drain_count", 32'(a.count), 0);
    chk("single_drain_empty", 32'(a.empty), 1);

    // FULL: 16 writes with flag tracking
    for (int i = 0; i < 16; i++) begin
      a.wr_en = 1'b1; a.wdata = 8'(32'h20 + i); cycle();
      chk("fill_count", 32'(a.count), i + 1);
      chk("fill_af", 32'(a.almost_full), 32'((i + 1) >= 14));
      chk("fill_ae", 32'(a.almost_empty), 32'((i + 1) <= 2));
      chk("fill_full", 32'(a.full), 32'((i + 1) == 16));
      chk("fill_empty", 32'(a.empty), 0);
    end
    a.wr_en = 1'b0;

    // OVER_FLOW: 17th write rejected
    a.wr_en = 1'b1; a.wdata = 8'hEE; cycle(); a.wr_en = 1'b0;
    chk("ovf_pulse", 32'(a.overflow), 1);
    chk("ovf_count", 32'(a.count), 16);
    chk("ovf_full", 32'(a.full), 1);
    cycle();
    chk("ovf_clear", 32'(a.overflow), 0);

    // FULL_RW: push+pop while full for 5 cycles
    for (int k = 0; k < 5; k++) begin
`ifdef SYN_FIFO_FWFT_EN
      chk("full_rw_data", 32'(a.rdata), 32'h20 + k);
`endif
      a.wr_en = 1'b1; a.rd_en = 1'b1; a.wdata = 8'(32'h30 + k); cycle();
`ifndef SYN_FIFO_FWFT_EN
      chk("full_rw_data", 32'(a.rdata), 32'h20 + k);
`endif
      chk("full_rw_count", 32'(a.count), 16);
      chk("full_rw_full", 32'(a.full), 1);
      chk("full_rw_ovf", 32'(a.overflow), 0);
      chk("full_rw_udf", 32'(a.underflow), 0);
    end
    a.wr_en = 1'b0; a.rd_en = 1'b0;

    // Drain: remainder of original words, then the words pushed while full
    for (int j = 0; j < 11; j++) pop_a(8'(32'h25 + j));
    for (int j = 0; j < 5; j++) pop_a(8'(32'h30 + j));
    chk("drain_count", 32'(a.count), 0);
    chk("drain_empty", 32'(a.empty), 1);
    chk("drain_ae", 32'(a.almost_empty), 1);
    chk("drain_full", 32'(a.full), 0);

    // UNDERFLOW: 17th read rejected
    a.rd_en = 1'b1; cycle(); a.rd_en = 1'b0;
    chk("udf_pulse", 32'(a.underflow), 1);
    chk("udf_count", 32'(a.count), 0);
    cycle();
    chk("udf_clear", 32'(a.underflow), 0);

    // Mid-operation reset discards contents and wins over a write
    for (int i = 0; i < 3; i++) begin
      a.wr_en = 1'b1; a.wdata = 8'(32'h50 + i); cycle();
    end
    chk("pre_rst_count", 32'(a.count), 3);
    res_a = 1'b1; a.wr_en = 1'b1; a.wdata = 8'h77; cycle();
    res_a = 1'b0; a.wr_en = 1'b0;
    chk("mid_rst_count", 32'(a.count), 0);
    chk("mid_rst_empty", 32'(a.empty), 1);
    chk("mid_rst_ae", 32'(a.almost_empty), 1);
`ifndef SYN_FIFO_FWFT_EN
    chk("mid_rst_rdata", 32'(a.rdata), 0);
`endif
    a.rd_en = 1'b1; cycle(); a.rd_en = 1'b0;
    chk("mid_rst_discard_udf", 32'(a.underflow), 1);
    cycle();

    // Single write of 0xA5 into empty FIFO
    a.wr_en = 1'b1; a.wdata = 8'hA5; cycle(); a.wr_en = 1'b0;
    chk("a5_empty", 32'(a.empty), 0);
    chk("a5_count", 32'(a.count), 1);
`ifdef SYN_FIFO_FWFT_EN
    chk("a5_fwft_rdata", 32'(a.rdata), 32'hA5);
`else
    chk("a5_rdata_hold", 32'(a.rdata), 0);
`endif
    pop_a(8'hA5);
    chk("a5_drain_empty", 32'(a.empty), 1);

    // WRAP on DEPTH=10: 3 passes of 7 words with gaps
    nb = 0;
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 7; w++) begin
        b.wr_en = 1'b1; b.wdata = 8'(32'h60 + p * 7 + w); cycle(); b.wr_en = 1'b0;
        nb++;
        chk("wrap_wr_count", 32'(b.count), nb);
        if (w % 3 == 1) begin
          cycle();
          chk("wrap_gap_count", 32'(b.count), nb);
        end
      end
      for (int r = 0; r < 7; r++) begin
        pop_b(8'(32'h60 + p * 7 + r));
        nb--;
        chk("wrap_rd_count", 32'(b.count), nb);
        if (r % 2 == 0) cycle();
      end
      chk("wrap_pass_empty", 32'(b.empty), 1);
    end

    // Reset in the middle of a pass on the DEPTH=10 instance
    for (int w = 0; w < 4; w++) begin
      b.wr_en = 1'b1; b.wdata = 8'(32'h90 + w); cycle();
    end
    b.wr_en = 1'b0;
    chk("wrap_pre_rst_count", 32'(b.count), 4);
    res_b = 1'b1; cycle(); res_b = 1'b0;
    chk("wrap_rst_count", 32'(b.count), 0);
    chk("wrap_rst_empty", 32'(b.empty), 1);
    b.wr_en = 1'b1; b.wdata = 8'hC3; cycle(); b.wr_en = 1'b0;
    pop_b(8'hC3);
    chk("wrap_post_rst_count", 32'(b.count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
